// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the pixel-domain raster generator.
// Defaults describe the 640x480@60 mode.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam bit          DEF_H_POL    = 1'b0;
  localparam bit          DEF_V_POL    = 1'b0;
  localparam int unsigned DEF_CORDW    = 10;

  typedef logic [DEF_CORDW-1:0] coord_t;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters gated by clock-stage lock,
// with every output registered from the same (hc, vc) so they describe one pixel.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          H_POL    = DEF_H_POL,
  parameter bit          V_POL    = DEF_V_POL,
  parameter int unsigned CORDW    = DEF_CORDW
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             locked,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_DE_END = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_DE_END = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_ACTIVE + V_FP + V_SYNC);

  // Counters must be able to reach TOTAL-1 without aliasing.
  if ((longint'(H_TOTAL) > (longint'(1) << CORDW)) ||
      (longint'(V_TOTAL) > (longint'(1) << CORDW))) begin : g_bad_cfg
    $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 2**CORDW");
  end

  logic [CORDW-1:0] hc_reg;
  logic [CORDW-1:0] vc_reg;
  logic [CORDW-1:0] hc_next;
  logic [CORDW-1:0] vc_next;
  logic             de_next;
  logic             hsync_next;
  logic             vsync_next;
  logic             line_next;
  logic             frame_next;

  always_comb begin
    hc_next = hc_reg + 1'b1;
    vc_next = vc_reg;
    if (hc_reg == H_LAST) begin
      hc_next = '0;
      vc_next = (vc_reg == V_LAST) ? '0 : vc_reg + 1'b1;
    end

    de_next    = (hc_reg < H_DE_END) && (vc_reg < V_DE_END);
    hsync_next = ((hc_reg >= HS_START) && (hc_reg < HS_END)) ? H_POL : ~H_POL;
    vsync_next = ((vc_reg >= VS_START) && (vc_reg < VS_END)) ? V_POL : ~V_POL;
    line_next  = (hc_reg == '0);
    frame_next = (hc_reg == '0) && (vc_reg == '0);
  end

  // Loss of lock behaves exactly like reset, so a relock always restarts at (0,0).
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hc_reg <= '0;
      vc_reg <= '0;
      sx     <= '0;
      sy     <= '0;
      de     <= 1'b0;
      line   <= 1'b0;
      frame  <= 1'b0;
      hsync  <= ~H_POL;
      vsync  <= ~V_POL;
    end else if (!locked) begin
      hc_reg <= '0;
      vc_reg <= '0;
      sx     <= '0;
      sy     <= '0;
      de     <= 1'b0;
      line   <= 1'b0;
      frame  <= 1'b0;
      hsync  <= ~H_POL;
      vsync  <= ~V_POL;
    end else begin
      hc_reg <= hc_next;
      vc_reg <= vc_next;
      sx     <= hc_reg;
      sy     <= vc_reg;
      de     <= de_next;
      line   <= line_next;
      frame  <= frame_next;
      hsync  <= hsync_next;
      vsync  <= vsync_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a default 640x480 instance and a small, positive-polarity
// instance share stimulus and are both checked every cycle against a raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] sx;
    logic [9:0] sy;
    logic       de;
    logic       hs;
    logic       vs;
    logic       line;
    logic       frame;
  } obs_t;

  typedef struct {
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
    int hp; int vp;
  } cfg_t;

  typedef struct {
    int   at_n;
    obs_t want;
  } vec_t;

  localparam cfg_t CFG_D = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
  localparam cfg_t CFG_S = '{16, 4, 6, 4, 12, 2, 2, 3, 1, 1};

  logic       clk_pix;
  logic       rst_n;
  logic       locked;
  logic [9:0] sx_d, sy_d;
  logic       hsync_d, vsync_d, de_d, line_d, frame_d;
  logic [5:0] sx_s, sy_s;
  logic       hsync_s, vsync_s, de_s, line_s, frame_s;

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;   // consecutive locked, out-of-reset edges seen
  vec_t vecs[11];

  vga_timing_gen dut_d (
    .clk_pix(clk_pix), .rst_n(rst_n), .locked(locked),
    .sx(sx_d), .sy(sy_d), .hsync(hsync_d), .vsync(vsync_d),
    .de(de_d), .line(line_d), .frame(frame_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b1), .V_POL(1'b1), .CORDW(6)
  ) dut_s (
    .clk_pix(clk_pix), .rst_n(rst_n), .locked(locked),
    .sx(sx_s), .sy(sy_s), .hsync(hsync_s), .vsync(vsync_s),
    .de(de_s), .line(line_s), .frame(frame_s)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  function automatic obs_t mk(input int x, input int y, input logic d, input logic h,
                              input logic v, input logic l, input logic f);
    obs_t o;
    o.sx = 10'(x); o.sy = 10'(y); o.de = d; o.hs = h; o.vs = v; o.line = l; o.frame = f;
    return o;
  endfunction

  // Position is simply (cnt-1) pixels into an endless raster of ht*vt pixels.
  function automatic obs_t model(input int cnt, input cfg_t c);
    obs_t e;
    int ht, vt, p, x, y;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    e = mk(0, 0, 1'b0, c.hp == 0, c.vp == 0, 1'b0, 1'b0);
    if (cnt > 0) begin
      p = (cnt - 1) % (ht * vt);
      x = p % ht;
      y = p / ht;
      e.sx    = 10'(x);
      e.sy    = 10'(y);
      e.de    = (x < c.ha) && (y < c.va);
      e.hs    = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hsw) ? (c.hp != 0) : (c.hp == 0);
      e.vs    = (y >= c.va + c.vf && y < c.va + c.vf + c.vsw) ? (c.vp != 0) : (c.vp == 0);
      e.line  = (x == 0);
      e.frame = (x == 0) && (y == 0);
    end
    return e;
  endfunction

  function automatic obs_t got_d();
    return mk(int'(sx_d), int'(sy_d), de_d, hsync_d, vsync_d, line_d, frame_d);
  endfunction

  function automatic obs_t got_s();
    return mk(int'(sx_s), int'(sy_s), de_s, hsync_s, vsync_s, line_s, frame_s);
  endfunction

  task automatic check_one(input string name, input obs_t got, input obs_t want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s n=%0d got sx=%0d sy=%0d de=%b hs=%b vs=%b line=%b frame=%b want sx=%0d sy=%0d de=%b hs=%b vs=%b line=%b frame=%b",
               name, n, got.sx, got.sy, got.de, got.hs, got.vs, got.line, got.frame,
               want.sx, want.sy, want.de, want.hs, want.vs, want.line, want.frame);
    end
  endtask

  task automatic cmp_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_both(input string name);
    check_one({name, "_d"}, got_d(), model(n, CFG_D));
    check_one({name, "_s"}, got_s(), model(n, CFG_S));
  endtask

  task automatic step(input string name);
    @(posedge clk_pix);
    if (!rst_n || !locked) n = 0;
    else n++;
    #1;
    check_both(name);
  endtask

  task automatic add_vec(input int idx, input int at, input obs_t w);
    vecs[idx].at_n = at;
    vecs[idx].want = w;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low, lines, des, frames, first_f, period, vs_hi, run, max_run, de_blank, hs_hi;

    //           idx  n     sx   sy  de    hs    vs    line  frame
    add_vec(0,  1,    mk(0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    add_vec(1,  2,    mk(1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    add_vec(2,  640,  mk(639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    add_vec(3,  641,  mk(640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    add_vec(4,  656,  mk(655, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    add_vec(5,  657,  mk(656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    add_vec(6,  752,  mk(751, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    add_vec(7,  753,  mk(752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    add_vec(8,  800,  mk(799, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    add_vec(9,  801,  mk(0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    add_vec(10, 4641, mk(640, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));

    // Reset applied between edges must act immediately.
    rst_n  = 1'b1;
    locked = 1'b0;
    #2 rst_n = 1'b0;
    n = 0;
    #1 check_both("reset_async");
    repeat (2) step("reset_hold");
    rst_n = 1'b1;
    repeat (3) step("unlocked_hold");
    locked = 1'b1;

    foreach (vecs[i]) begin
      while (n < vecs[i].at_n) step("run");
      check_one($sformatf("vec%0d", i), got_d(), vecs[i].want);
    end

    // One full line on the default timing.
    hs_low = 0; lines = 0; des = 0;
    for (int i = 0; i < 800; i++) begin
      step("line_run");
      if (!hsync_d) hs_low++;
      if (line_d)   lines++;
      if (de_d)     des++;
    end
    cmp_int("hsync_low_per_line", hs_low, 96);
    cmp_int("line_pulses_per_line", lines, 1);
    cmp_int("de_per_line", des, 640);

    // Two full frames on the small timing (30x19 = 570 cycles per frame).
    frames = 0; first_f = -1; period = -1; vs_hi = 0; run = 0; max_run = 0;
    de_blank = 0; hs_hi = 0;
    for (int i = 0; i < 1140; i++) begin
      step("frame_run");
      if (frame_s) begin
        frames++;
        if (first_f < 0) first_f = i;
        else if (period < 0) period = i - first_f;
      end
      if (vsync_s) begin
        vs_hi++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (de_s && sy_s >= 6'd12) de_blank++;
      if (hsync_s) hs_hi++;
    end
    cmp_int("frame_pulses", frames, 2);
    cmp_int("frame_period", period, 570);
    cmp_int("vsync_active_cycles", vs_hi, 120);
    cmp_int("vsync_run_length", max_run, 60);
    cmp_int("de_in_vblank", de_blank, 0);
    cmp_int("hsync_active_cycles", hs_hi, 228);

    // Lock lost mid-line: reset values at the next edge, restart from (0,0).
    for (int k = 0; k < 1000 && sx_d != 10'd300; k++) step("seek300");
    cmp_int("reach_sx300", int'(sx_d), 300);
    locked = 1'b0;
    step("drop_lock");
    check_one("drop_lock_values", got_d(), mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    repeat (3) step("drop_hold");
    locked = 1'b1;
    step("relock");
    check_one("relock_first", got_d(), mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));

    // Reset asserted between edges at sx=100.
    for (int k = 0; k < 1000 && sx_d != 10'd100; k++) step("seek100");
    cmp_int("reach_sx100", int'(sx_d), 100);
    #2 rst_n = 1'b0;
    n = 0;
    #1 check_both("async_rst_mid");
    cmp_int("small_hsync_rest_level", int'(hsync_s), 0);
    repeat (2) step("rst_hold");
    rst_n = 1'b1;
    step("rst_release");
    check_one("rst_release_first", got_s(), mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));

    // Random lock drops and asynchronous resets.
    for (int i = 0; i < 20000; i++) begin
      step("rand");
      if (locked && $urandom_range(0, 599) == 0) locked = 1'b0;
      else if (!locked && $urandom_range(0, 3) == 0) locked = 1'b1;
      if ($urandom_range(0, 2499) == 0) begin
        #($urandom_range(1, 3)) rst_n = 1'b0;
        n = 0;
        #1 check_both("rand_async_rst");
        step("rand_rst_hold");
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
